// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle, signs fixed up on completion.
// Define MULDIV_DIV_EN to build the restoring divider; without it DIV/DIVU starts are ignored.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   p_lo;
  logic [WIDTH-1:0]   b_mag;
  logic               sign_op;
  logic               neg_a;
  logic               neg_b;

  logic               accept;
  logic               a_neg_in;
  logic               b_neg_in;
  logic [WIDTH-1:0]   a_mag_in;
  logic [WIDTH-1:0]   b_mag_in;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

`ifdef MULDIV_DIV_EN
  logic               div_op;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
`endif

  always_comb begin
    a_neg_in = ~op[0] & a[WIDTH-1];
    b_neg_in = ~op[0] & b[WIDTH-1];
    a_mag_in = a_neg_in ? -a : a;
    b_mag_in = b_neg_in ? -b : b;
`ifdef MULDIV_DIV_EN
    accept = (state == IDLE) && start;
`else
    accept = (state == IDLE) && start && !op[1];
`endif
  end

  // p_hi/p_lo hold accumulator:multiplier for multiply and remainder:dividend for divide
  always_comb begin
    mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});
    step_hi  = mul_sum[WIDTH:1];
    step_lo  = {mul_sum[0], p_lo[WIDTH-1:1]};
    prod     = {p_hi, p_lo};
    prod_fix = (sign_op && (neg_a ^ neg_b)) ? -prod : prod;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    div_shift = {p_hi, p_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_mag};
    quo_fix   = (sign_op && (neg_a ^ neg_b)) ? -p_lo : p_lo;
    rem_fix   = (sign_op && neg_a) ? -p_hi : p_hi;
    if (div_op) begin
      step_hi = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
      step_lo = {p_lo[WIDTH-2:0], ~div_trial[WIDTH]};
      if (b_mag == '0) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
`endif
  end

  // The overflow case (most-negative / -1) falls out of the magnitude path with no special case
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      b_mag   <= '0;
      sign_op <= 1'b0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_op  <= 1'b0;
      a_raw   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (accept) begin
            state   <= RUN;
            busy    <= 1'b1;
            cnt     <= '0;
            sign_op <= ~op[0];
            neg_a   <= a_neg_in;
            neg_b   <= b_neg_in;
            p_hi    <= '0;
            p_lo    <= a_mag_in;
            b_mag   <= b_mag_in;
`ifdef MULDIV_DIV_EN
            div_op  <= op[1];
            a_raw   <= a;
`endif
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            hi    <= res_hi;
            lo    <= res_lo;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt  <= cnt + CW'(1);
            p_hi <= step_hi;
            p_lo <= step_lo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): cycle-level reference model plus directed literal checks.
// Divide checks are enabled when MULDIV_DIV_EN is defined, otherwise divide starts must be ignored.
module tb_muldiv_unit;
  localparam int WIDTH  = 32;
  localparam int PERIOD = 10;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int  total = 0;
  int  bad = 0;
  bit  check_en = 1'b0;
  time accept_t = 0;

  logic        m_busy;
  logic        m_done;
  int          m_left;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #(PERIOD/2) clk = ~clk;

  // Architectural result {hi, lo} straight from integer arithmetic
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    logic [31:0] q;
    logic [31:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: return 64'(sx * sy);
      2'b01: return {32'h0, x} * {32'h0, y};
      2'b10: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        q = 32'(sx / sy);
        r = 32'(sx % sy);
        return {r, q};
      end
      default: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Timing model: accepted op stays busy for WIDTH+1 edges, then writes HI/LO and pulses done
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 0) begin
          m_hi   <= r_hi;
          m_lo   <= r_lo;
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_left <= m_left - 1;
        end
      end else begin
        if (hi_we) m_hi <= wdata;
        if (lo_we) m_lo <= wdata;
        if (start && (DIV_EN || !op[1])) begin
          m_busy <= 1'b1;
          m_left <= WIDTH;
          {r_hi, r_lo} <= ref_result(op, a, b);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model busy", 64'(busy), 64'(m_busy));
      checkOutput("model done", 64'(done), 64'(m_done));
      checkOutput("model hi", 64'(hi), 64'(m_hi));
      checkOutput("model lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic applyStimulus(input logic s, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input logic hw, input logic lw, input logic [31:0] wd);
    start = s;
    op    = o;
    a     = x;
    b     = y;
    hi_we = hw;
    lo_we = lw;
    wdata = wd;
    @(posedge clk);
    accept_t = $time;
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
  endtask

  task automatic waitDone(input string name, output int lat);
    lat = -1;
    for (int i = 0; i < WIDTH + 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = int'(($time - PERIOD/2 - accept_t) / PERIOD);
        return;
      end
    end
    total++;
    bad++;
    $display("[TB] FAIL %s timeout: actual=no done required=done within %0d cycles", name, WIDTH + 10);
  endtask

  task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, o, x, y, 1'b0, 1'b0, 32'h0);
    waitDone(name, lat);
    checkOutput({name, " latency"}, 64'(lat), 64'd33);
    checkOutput({name, " hi"}, 64'(hi), 64'(exp_hi));
    checkOutput({name, " lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    #(PERIOD * 100000);
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int n_done;

    checkOutput("ref mult", ref_result(2'b00, 32'hFFFFFFFD, 32'd7), 64'hFFFFFFFF_FFFFFFEB);
    checkOutput("ref multu", ref_result(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
    checkOutput("ref div", ref_result(2'b10, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    checkOutput("ref div ovf", ref_result(2'b10, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);
    #1;
    rst_n = 1'b1;
    check_en = 1'b1;

    runOp("mult", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);

    runOp("multu", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    applyStimulus(1'b1, 2'b01, 32'd3, 32'd5, 1'b0, 1'b0, 32'h0);
    checkOutput("b2b accepted", 64'(busy), 64'd1);
    waitDone("b2b", lat);
    checkOutput("b2b latency", 64'(lat), 64'd33);
    checkOutput("b2b lo", 64'(lo), 64'h0000000F);

    @(posedge clk);
    #1;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1234);
    checkOutput("hi_we idle", 64'(hi), 64'h1234);

    applyStimulus(1'b1, 2'b00, 32'd100, 32'hFFFFFFFE, 1'b0, 1'b0, 32'h0);
    repeat (9) @(posedge clk);
    #1;
    applyStimulus(1'b1, 2'b01, 32'd7, 32'd7, 1'b0, 1'b1, 32'hDEAD);
    checkOutput("lo_we while busy", 64'(lo), 64'h0000000F);
    accept_t = accept_t - 10 * PERIOD;
    waitDone("ignored start", lat);
    checkOutput("ignored start latency", 64'(lat), 64'd33);
    checkOutput("ignored start hi", 64'(hi), 64'hFFFFFFFF);
    checkOutput("ignored start lo", 64'(lo), 64'hFFFFFF38);

    @(posedge clk);
    #1;
    applyStimulus(1'b1, 2'b00, 32'd5, 32'd6, 1'b0, 1'b0, 32'h0);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort hi", 64'(hi), 64'd0);
    checkOutput("abort lo", 64'(lo), 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    checkOutput("no done after abort", 64'(n_done), 64'd0);
    checkOutput("abort lo kept", 64'(lo), 64'd0);

`ifdef MULDIV_DIV_EN
    runOp("div", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("div ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    runOp("divu by zero", 2'b11, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF);
    runOp("div neg divisor", 2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
`else
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 2'b10, 32'd9, 32'd3, 1'b0, 1'b0, 32'h0);
    checkOutput("div ignored busy", 64'(busy), 64'd0);
    applyStimulus(1'b1, 2'b11, 32'd5, 32'd0, 1'b0, 1'b0, 32'h0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    checkOutput("div ignored done", 64'(n_done), 64'd0);
    checkOutput("div ignored lo", 64'(lo), 64'd0);
`endif

    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      #1;
      start = ($urandom_range(0, 5) == 0);
      op    = 2'($urandom);
      a     = pick();
      b     = pick();
      hi_we = ($urandom_range(0, 7) == 0);
      lo_we = ($urandom_range(0, 7) == 0);
      wdata = $urandom;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width; legal range 4..64.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  launch request, sampled on the rising edge.
REQ-005 op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 a  input  WIDTH  multiplicand or dividend, latched when start is accepted.
REQ-007 b  input  WIDTH  multiplier or divisor, latched when start is accepted.
REQ-008 hi_we  input  1  direct write of wdata into HI (MTHI).
REQ-009 lo_we  input  1  direct write of wdata into LO (MTLO).
REQ-010 wdata  input  WIDTH  data for hi_we and lo_we.
REQ-011 busy  output  1  operation in progress.
REQ-012 done  output  1  one-cycle pulse marking HI/LO updated by a completed operation.
REQ-013 hi  output  WIDTH  HI register.
REQ-014 lo  output  WIDTH  LO register.

Function
REQ-015 The FSM SHALL have states IDLE and RUN; a start sampled in IDLE SHALL be accepted at edge N, latch a, b and op, and enter RUN.
REQ-016 RUN SHALL iterate one bit per cycle: shift-add for multiply, restoring shift-subtract for divide; operand magnitudes are used, and the sign is fixed up on completion.
REQ-017 busy SHALL be 1 after edges N through N+WIDTH; at edge N+WIDTH+1, hi/lo SHALL update, busy SHALL fall, and done SHALL be 1 for exactly one cycle.
REQ-018 MULT/MULTU SHALL produce {hi,lo} = the full 2*WIDTH-bit product, two's-complement for MULT.
REQ-019 DIV/DIVU SHALL produce lo = quotient and hi = remainder; signed quotient truncates toward zero, and the signed remainder takes the dividend's sign.
REQ-020 Divide by zero SHALL complete with normal latency: lo = all ones, hi = a.
REQ-021 Signed overflow (most-negative / -1) SHALL give lo = most-negative value and hi = 0.
REQ-022 start while busy=1 SHALL be ignored with no effect; start in the done cycle SHALL be accepted (back-to-back).
REQ-023 hi_we/lo_we SHALL write wdata at the edge only when busy=0; they are ignored while busy=1.
REQ-024 hi_we/lo_we coincident with an accepted start SHALL write; the operation's result overwrites both registers at completion.
REQ-025 hi and lo SHALL change only at completion, on a direct write, or on reset.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, busy=0, done=0, hi=0, lo=0, and clear the iteration counter and operand registers.
REQ-027 Reset during RUN SHALL abort the operation; no done pulse and no result write SHALL follow its release.

Configuration
REQ-028 Macro MULDIV_DIV_EN defined: all four ops SHALL be supported.
REQ-029 Macro MULDIV_DIV_EN undefined: the divider datapath SHALL be absent; start with op[1]=1 SHALL be ignored (no busy, no done, hi/lo unchanged); MULT/MULTU are unaffected.

Verification (WIDTH=32)
REQ-030 MULT a=0xFFFFFFFD, b=7 -> done 33 edges after the accept edge, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-031 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; a back-to-back start in the done cycle is accepted.
REQ-032 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=0x00000005 after normal latency.
REQ-034 Second start at busy cycle 10 -> ignored, first result intact; rst_n low at busy cycle 20 -> busy=0, hi=lo=0, no done after release.
REQ-035 hi_we with wdata=0x1234 in IDLE -> hi=0x1234 next cycle; lo_we during busy -> lo unchanged until done.
